// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake on both sides.
// Single-cycle ops complete on the accepting edge. DIV with a non-zero divisor runs a
// restoring divider that produces one quotient bit per cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;

  logic             w_in_xfer;
  logic             w_start_div;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic             w_alu_err;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign in_ready  = !rst && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
  assign out_valid = (r_state == S_DONE);
  assign w_in_xfer = in_valid && in_ready;
  // Only a real division iterates; divide-by-zero is resolved in one cycle.
  assign w_start_div = (sel == OP_DIV) && (B != '0);

  assign res   = r_res;
  assign zero  = r_zero;
  assign neg   = r_neg;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign err   = r_err;

  // WIDTH+1 bit add/sub; the top bit is carry-out or borrow.
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  // Single-cycle result and flags for the op presented on the inputs.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    w_alu_err   = 1'b0;
    case (sel)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
        w_alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:  w_alu_res = A * B;
      // Reaches the output only for B==0; non-zero divisors go through the iterator.
      OP_DIV: begin
        w_alu_res = '1;
        w_alu_err = 1'b1;
      end
      OP_AND:  w_alu_res = A & B;
      OP_OR:   w_alu_res = A | B;
      OP_XOR:  w_alu_res = A ^ B;
      OP_NOT:  w_alu_res = ~A;
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
      default: w_alu_err = 1'b1;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_rem_sh - {1'b0, r_dvs};
    w_qbit    = !w_trial[WIDTH];
    w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
  end

  // Control FSM plus the result/flag and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_in_xfer) begin
            if (w_start_div) begin
              r_rem   <= '0;
              r_quo   <= A;
              r_dvs   <= B;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end else begin
              r_res   <= w_alu_res;
              r_zero  <= (w_alu_res == '0);
              r_neg   <= w_alu_res[WIDTH-1];
              r_carry <= w_alu_carry;
              r_ovf   <= w_alu_ovf;
              r_err   <= w_alu_err;
              r_state <= S_DONE;
            end
          end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_res   <= w_quo_nxt;
            r_zero  <= (w_quo_nxt == '0);
            r_neg   <= w_quo_nxt[WIDTH-1];
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a scoreboard of expected results.
module tb_alu_multicycle;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero;
  logic        neg;
  logic        carry;
  logic        ovf;
  logic        err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model using 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      sr;
    logic [63:0] wide;
    e   = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (s)
      4'd0: begin
        wide    = {32'd0, a} + {32'd0, b};
        e.res   = wide[31:0];
        e.carry = wide[32];
        sr      = sa + sbv;
        e.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        e.res   = a - b;
        e.carry = (a < b);
        sr      = sa - sbv;
        e.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: begin
        wide  = {32'd0, a} * {32'd0, b};
        e.res = wide[31:0];
      end
      4'd3: begin
        if (b == 0) begin
          e.res = 32'hFFFF_FFFF;
          e.err = 1'b1;
        end else begin
          e.res = a / b;
        end
      end
      4'd4: e.res = a & b;
      4'd5: e.res = a | b;
      4'd6: e.res = a ^ b;
      4'd7: e.res = ~a;
      4'd8: e.res = (a < b) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    e.neg  = e.res[31];
    return e;
  endfunction

  task automatic send(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                      input bit push);
    int n;
    @(negedge clk);
    sel      = s;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    n        = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept within bound", 64'(n < 100), 64'd1);
    if (push) sb.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    chk({tag, " sb occupancy"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " res"}, 64'(res), 64'(e.res));
      chk({tag, " flags zncve"}, 64'({zero, neg, carry, ovf, err}),
          64'({e.zero, e.neg, e.carry, e.ovf, e.err}));
    end
  endtask

  // Waits for out_valid (bounded), checks latency and result, then lets the transfer happen.
  task automatic collect(input string tag, input int exp_lat, output int low);
    int n;
    n   = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 200);
    chk({tag, " cycles to out_valid"}, 64'(n), 64'(exp_lat));
    cmp_out(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          low;
    int          seen;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t_sel [8];
    logic [31:0] t_a   [8];
    logic [31:0] t_b   [8];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    sel       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    chk("reset flags", 64'({zero, neg, carry, ovf, err}), 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    // Arithmetic corner cases
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    collect("add wrap", 1, low);
    send(4'd1, 32'd5, 32'd7, 1'b1);
    collect("sub borrow", 1, low);
    send(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
    collect("add ovf", 1, low);

    // Iterative divide
    send(4'd3, 32'd100, 32'd7, 1'b1);
    collect("div 100/7", 33, low);
    chk("div in_ready low cycles", 64'(low), 64'd32);

    // Divide by zero and illegal opcode
    send(4'd3, 32'd9, 32'd0, 1'b1);
    collect("div by zero", 1, low);
    send(4'b1010, 32'd3, 32'd4, 1'b1);
    collect("illegal op", 1, low);

    // Directed sweep of the remaining ops
    t_sel = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd1};
    t_a   = '{32'h0001_0001, 32'hF0F0_1234, 32'h0F00_00A0, 32'hAAAA_5555,
              32'h0000_FFFF, 32'd3, 32'd9, 32'h8000_0000};
    t_b   = '{32'h0001_0001, 32'h0FF0_FF00, 32'h00F0_000A, 32'hFFFF_0000,
              32'd0, 32'd9, 32'd3, 32'd1};
    for (int i = 0; i < 8; i++) begin
      send(t_sel[i], t_a[i], t_b[i], 1'b1);
      collect("sweep", 1, low);
    end

    // Random ops including long divides and illegal codes
    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom_range(0, 9));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      send(s, a, b, 1'b1);
      collect("random", (s == 4'd3 && b != 0) ? 33 : 1, low);
    end

    // Backpressure, then simultaneous retire and issue
    out_ready = 1'b0;
    send(4'd2, 32'd3, 32'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A   = $urandom;
      B   = $urandom;
      sel = 4'd0;
      #1;
      chk("bp out_valid held", 64'(out_valid), 64'd1);
      chk("bp res held", 64'(res), 64'd12);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    sel       = 4'd4;
    A         = 32'h0000_F0F0;
    B         = 32'h0000_FF00;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp in_ready with out_ready", 64'(in_ready), 64'd1);
    cmp_out("bp mul");
    sb.push_back(model(4'd4, 32'h0000_F0F0, 32'h0000_FF00));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("and after bp", 1, low);

    // Reset in the middle of a divide
    send(4'd3, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-div rst out_valid", 64'(out_valid), 64'd0);
    chk("mid-div rst in_ready", 64'(in_ready), 64'd0);
    chk("mid-div rst res", 64'(res), 64'd0);
    chk("mid-div rst flags", 64'({zero, neg, carry, ovf, err}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no stale output after rst", 64'(seen), 64'd0);
    chk("idle in_ready after rst", 64'(in_ready), 64'd1);

    // Block still works after the aborted divide
    send(4'd3, 32'd1000, 32'd3, 1'b1);
    collect("div after rst", 33, low);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
